// File: rtl/cnt_arbiter_pkg.sv
// Shared types and constants for the counting arbiter.
package cnt_arbiter_pkg;

    // Default width of the shared counter and of each length field.
    localparam int unsigned DefaultWidth = 3;

    // Job sequencing: grant, clear the counter, count to target, signal completion.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StClear = 2'd1,
        StRun   = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/cnt_core.sv
// W-bit counter with full clear, soft clear of the two low bits, and increment enable.
module cnt_core
    import cnt_arbiter_pkg::*;
#(
    parameter int unsigned W = DefaultWidth
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic         rnd,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] LowMask = W'(3);

    logic [W-1:0] count_q, count_d;

    // Next count: clr zeroes everything; while enabled, rnd drops bits [1:0], else increment.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            if (rnd) begin
                count_d = count_q & ~LowMask;
            end else begin
                count_d = count_q + W'(1);
            end
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cnt_arbiter.sv
// Two-requester round-robin arbiter that runs a shared counter up to the
// granted requester's length, then pulses done back to that requester.
module cnt_arbiter
    import cnt_arbiter_pkg::*;
#(
    parameter int unsigned W = DefaultWidth
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req,
    input  logic [W-1:0] len0,
    input  logic [W-1:0] len1,
    input  logic         hold,
    input  logic         rnd,
    output logic [1:0]   gnt,
    output logic [1:0]   done,
    output logic         busy,
    output logic [W-1:0] count
);

    state_e       state_q, state_d;
    logic [1:0]   gnt_q, gnt_d;
    logic [1:0]   done_q, done_d;
    logic [W-1:0] tgt_q, tgt_d;
    logic         ptr_q, ptr_d;
    logic         sel_q, sel_d;

    logic         pick;
    logic         match;
    logic         run;
    logic         cnt_en;
    logic         cnt_clr;

    // Tie goes to ptr; a lone request wins regardless of ptr.
    assign pick    = (req == 2'b11) ? ptr_q : req[1];
    assign run     = (state_q == StRun);
    assign match   = (count == tgt_q);
    // Target match outranks hold and rnd, so a zero-length job exits untouched.
    assign cnt_en  = run && !match && !hold;
    assign cnt_clr = (state_q == StClear);

    // FSM next-state, grant, target latch and completion pulse.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        tgt_d   = tgt_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        done_d  = 2'b00;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    sel_d   = pick;
                    tgt_d   = pick ? len1 : len0;
                    gnt_d   = pick ? 2'b10 : 2'b01;
                    state_d = StClear;
                end
            end
            StClear: begin
                state_d = StRun;
            end
            StRun: begin
                if (match) begin
                    gnt_d   = 2'b00;
                    done_d  = sel_q ? 2'b10 : 2'b01;
                    ptr_d   = ~sel_q;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset wins over everything and aborts any job without done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            tgt_q   <= '0;
            ptr_q   <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            tgt_q   <= tgt_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
        end
    end

    cnt_core #(
        .W(W)
    ) u_core (
        .clk  (clk),
        .rst  (rst),
        .en   (cnt_en),
        .clr  (cnt_clr),
        .rnd  (rnd),
        .count(count)
    );

    assign gnt  = gnt_q;
    assign done = done_q;
    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_cnt_arbiter.sv
// Directed bench for cnt_arbiter with hand-computed expectations.
module tb_cnt_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [2:0] len0;
    logic [2:0] len1;
    logic       hold;
    logic       rnd;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;
    logic [2:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    cnt_arbiter #(
        .W(3)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .len0 (len0),
        .len1 (len1),
        .hold (hold),
        .rnd  (rnd),
        .gnt  (gnt),
        .done (done),
        .busy (busy),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are stable 1 time unit after it.
    task step;
        @(posedge clk);
        #1;
    endtask

    task do_reset;
        rst  = 1'b1;
        req  = 2'b00;
        hold = 1'b0;
        rnd  = 1'b0;
        step;
        rst  = 1'b0;
    endtask

    task test_reset;
        len0 = 3'd0;
        len1 = 3'd0;
        do_reset;
        n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
        n_checks++; if (done !== 2'b00) begin n_fail++; $display("FAIL reset_done: got %b expected 00", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    endtask

    task test_single;
        do_reset;
        req  = 2'b01;
        len0 = 3'd5;
        step;
        n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL single_gnt: got %b expected 01", gnt); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", busy); end
        step;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL single_clr: got %0d expected 0", count); end
        for (int k = 1; k <= 5; k++) begin
            step;
            n_checks++; if (count !== 3'(k) || done !== 2'b00) begin n_fail++; $display("FAIL single_step: count=%0d done=%b expected %0d/00", count, done, k); end
        end
        step;
        n_checks++; if (done !== 2'b01) begin n_fail++; $display("FAIL single_done: got %b expected 01", done); end
        n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL single_gnt_drop: got %b expected 00", gnt); end
        n_checks++; if (count !== 3'd5) begin n_fail++; $display("FAIL single_count_hold: got %0d expected 5", count); end
        req = 2'b00;
        step;
        n_checks++; if (done !== 2'b00) begin n_fail++; $display("FAIL single_done_pulse: got %b expected 00", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_drop: got %b expected 0", busy); end
        n_checks++; if (count !== 3'd5) begin n_fail++; $display("FAIL single_idle_count: got %0d expected 5", count); end
        // ptr now favours requester 1, but a lone req0 must still win.
        req  = 2'b01;
        len0 = 3'd1;
        step;
        n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL lone_gnt: got %b expected 01", gnt); end
        step;
        step;
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL lone_count: got %0d expected 1", count); end
        step;
        n_checks++; if (done !== 2'b01) begin n_fail++; $display("FAIL lone_done: got %b expected 01", done); end
        req = 2'b00;
        step;
    endtask

    task test_back_to_back;
        logic [1:0] exp;
        int waited;
        do_reset;
        req  = 2'b11;
        len0 = 3'd1;
        len1 = 3'd2;
        for (int j = 0; j < 4; j++) begin
            exp = (j % 2 == 0) ? 2'b01 : 2'b10;
            waited = 0;
            step;
            while (gnt == 2'b00 && waited < 20) begin step; waited++; end
            n_checks++; if (gnt !== exp) begin n_fail++; $display("FAIL rr_gnt job %0d: got %b expected %b", j, gnt, exp); end
            waited = 0;
            while (done == 2'b00 && waited < 20) begin step; waited++; end
            n_checks++; if (done !== exp) begin n_fail++; $display("FAIL rr_done job %0d: got %b expected %b", j, done, exp); end
        end
        req = 2'b00;
        step;
        step;
    endtask

    task test_rnd;
        do_reset;
        req  = 2'b10;
        len1 = 3'd6;
        step;
        n_checks++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL rnd_gnt: got %b expected 10", gnt); end
        step;
        for (int k = 1; k <= 5; k++) step;
        n_checks++; if (count !== 3'd5) begin n_fail++; $display("FAIL rnd_pre: got %0d expected 5", count); end
        rnd = 1'b1;
        step;
        rnd = 1'b0;
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL rnd_clear: got %0d expected 4", count); end
        step;
        n_checks++; if (count !== 3'd5) begin n_fail++; $display("FAIL rnd_cont5: got %0d expected 5", count); end
        step;
        n_checks++; if (count !== 3'd6) begin n_fail++; $display("FAIL rnd_cont6: got %0d expected 6", count); end
        step;
        n_checks++; if (done !== 2'b10) begin n_fail++; $display("FAIL rnd_done: got %b expected 10", done); end
        req = 2'b00;
        step;
    endtask

    task test_zero_len;
        do_reset;
        req  = 2'b01;
        len0 = 3'd0;
        step;
        // Both soft controls asserted across the CLEAR and the only RUN cycle.
        rnd  = 1'b1;
        hold = 1'b1;
        step;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL zero_clr: got %0d expected 0", count); end
        step;
        n_checks++; if (done !== 2'b01) begin n_fail++; $display("FAIL zero_done: got %b expected 01", done); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL zero_count: got %0d expected 0", count); end
        rnd  = 1'b0;
        hold = 1'b0;
        req  = 2'b00;
        step;
    endtask

    task test_hold;
        do_reset;
        req  = 2'b01;
        len0 = 3'd7;
        step;
        step;
        step;
        step;
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL hold_pre: got %0d expected 2", count); end
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step;
            n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL hold_freeze %0d: got %0d expected 2", k, count); end
        end
        hold = 1'b0;
        for (int k = 3; k <= 7; k++) begin
            step;
            n_checks++; if (count !== 3'(k)) begin n_fail++; $display("FAIL hold_resume: got %0d expected %0d", count, k); end
        end
        step;
        n_checks++; if (done !== 2'b01) begin n_fail++; $display("FAIL hold_done: got %b expected 01", done); end
        req = 2'b00;
        step;
    endtask

    task test_rst_run;
        do_reset;
        req  = 2'b01;
        len0 = 3'd7;
        step;
        step;
        step;
        step;
        step;
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL rstrun_pre: got %0d expected 3", count); end
        rst = 1'b1;
        step;
        rst = 1'b0;
        req = 2'b00;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rstrun_count: got %0d expected 0", count); end
        n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL rstrun_gnt: got %b expected 00", gnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstrun_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 2'b00) begin n_fail++; $display("FAIL rstrun_done: got %b expected 00", done); end
        step;
        n_checks++; if (done !== 2'b00) begin n_fail++; $display("FAIL rstrun_done_late: got %b expected 00", done); end
    endtask

    task test_drop_req;
        do_reset;
        req  = 2'b10;
        len1 = 3'd2;
        step;
        n_checks++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL drop_gnt: got %b expected 10", gnt); end
        req = 2'b00;
        step;
        step;
        step;
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL drop_count: got %0d expected 2", count); end
        step;
        n_checks++; if (done !== 2'b10) begin n_fail++; $display("FAIL drop_done: got %b expected 10", done); end
        step;
    endtask

    initial begin
        rst  = 1'b1;
        req  = 2'b00;
        len0 = 3'd0;
        len1 = 3'd0;
        hold = 1'b0;
        rnd  = 1'b0;
        test_reset;
        test_single;
        test_back_to_back;
        test_rnd;
        test_zero_len;
        test_hold;
        test_rst_run;
        test_drop_req;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
